// File: rtl/fifo_ctrl_pkg.sv
// Shared encodings and defaults for the transaction-layer FIFO controller.
package fifo_ctrl_pkg;

    localparam int unsigned FIFO_DATA_WIDTH   = 10;
    localparam int unsigned FIFO_UMBRAL_WIDTH = 3;
    localparam int unsigned UMBRAL_SUP_RST    = 6;
    localparam int unsigned UMBRAL_INF_RST    = 1;

    // One-hot so the encoding can be driven straight onto every FIFO's state input.
    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_e;

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin arbiter; search starts one past the last grant.
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        // i = 4 wraps to last_grant itself, so a lone requester can win twice in a row.
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = last_grant + 2'(i);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter_ctrl.sv
// Sequences the VC FIFO bank, round-robin pops non-empty VCs and forwards words
// into the egress FIFO one cycle later under almost_full backpressure.
module fifo_arbiter_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = FIFO_DATA_WIDTH,
    parameter int unsigned NUM_VC         = 4,
    parameter int unsigned UMBRAL_WIDTH   = FIFO_UMBRAL_WIDTH,
    parameter int unsigned UMBRAL_SUP_DEF = UMBRAL_SUP_RST,
    parameter int unsigned UMBRAL_INF_DEF = UMBRAL_INF_RST
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMBRAL_WIDTH-1:0] umbral_superior_in,
    input  logic [UMBRAL_WIDTH-1:0] umbral_inferior_in,
    input  logic [NUM_VC-1:0]       fifo_empty,
    input  logic [DATA_WIDTH-1:0]   data_in_0,
    input  logic [DATA_WIDTH-1:0]   data_in_1,
    input  logic [DATA_WIDTH-1:0]   data_in_2,
    input  logic [DATA_WIDTH-1:0]   data_in_3,
    input  logic                    almost_full_out,
    output logic [3:0]              state,
    output logic [UMBRAL_WIDTH-1:0] umbral_superior,
    output logic [UMBRAL_WIDTH-1:0] umbral_inferior,
    output logic [NUM_VC-1:0]       pop,
    output logic                    push_out,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    idle
);

    state_e                  state_q;
    logic [UMBRAL_WIDTH-1:0] umbral_sup_q;
    logic [UMBRAL_WIDTH-1:0] umbral_inf_q;
    logic [1:0]              last_grant_q;
    logic [1:0]              sel_q;
    logic                    pop_q;

    logic [3:0]              req;
    logic [3:0]              gnt;
    logic [1:0]              gnt_idx;
    logic                    pop_any;
    logic [DATA_WIDTH-1:0]   data_in_arr [4];

    assign req = ~fifo_empty & {4{~almost_full_out}};

    rr_arbiter_4 u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    // A rising init stops new pops immediately, even before the FSM leaves ACTIVE.
    assign pop     = (state_q == ST_ACTIVE && !init) ? gnt : '0;
    assign pop_any = |pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RESET;
            umbral_sup_q <= UMBRAL_WIDTH'(UMBRAL_SUP_DEF);
            umbral_inf_q <= UMBRAL_WIDTH'(UMBRAL_INF_DEF);
            last_grant_q <= 2'd3;
            sel_q        <= 2'd0;
            pop_q        <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RESET: state_q <= ST_INIT;
                ST_INIT: begin
                    umbral_sup_q <= umbral_superior_in;
                    umbral_inf_q <= umbral_inferior_in;
                    if (!init) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (init) state_q <= ST_INIT;
                    else if (fifo_empty != 4'b1111) state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (init) state_q <= ST_INIT;
                    else if (fifo_empty == 4'b1111 && !pop_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_RESET;
            endcase
            pop_q <= pop_any;
            if (pop_any) begin
                sel_q        <= gnt_idx;
                last_grant_q <= gnt_idx;
            end
        end
    end

    assign data_in_arr[0] = data_in_0;
    assign data_in_arr[1] = data_in_1;
    assign data_in_arr[2] = data_in_2;
    assign data_in_arr[3] = data_in_3;

    // The source FIFO's registered data_out holds the word popped last cycle.
    assign push_out        = pop_q;
    assign data_out        = pop_q ? data_in_arr[sel_q] : '0;
    assign state           = state_q;
    assign idle            = (state_q == ST_IDLE);
    assign umbral_superior = umbral_sup_q;
    assign umbral_inferior = umbral_inf_q;

endmodule

// File: tb/tb_fifo_arbiter_ctrl.sv
// Self-checking bench: emulates the four VC FIFOs and checks the controller against
// a queue-based model of the arbitration and forwarding rules.
module tb_fifo_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [2:0] usup_in;
    logic [2:0] uinf_in;
    logic [3:0] fifo_empty;
    logic [9:0] din [4];
    logic       af;
    logic [3:0] state;
    logic [2:0] usup;
    logic [2:0] uinf;
    logic [3:0] pop;
    logic       push_out;
    logic [9:0] data_out;
    logic       idle;

    int n_cmp = 0;
    int n_err = 0;

    // Source FIFO contents: mem[k][hd[k] .. tl[k]-1].
    logic [9:0] mem [4][1024];
    int         hd [4];
    int         tl [4];

    always #5 clk = ~clk;

    fifo_arbiter_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .init               (init),
        .umbral_superior_in (usup_in),
        .umbral_inferior_in (uinf_in),
        .fifo_empty         (fifo_empty),
        .data_in_0          (din[0]),
        .data_in_1          (din[1]),
        .data_in_2          (din[2]),
        .data_in_3          (din[3]),
        .almost_full_out    (af),
        .state              (state),
        .umbral_superior    (usup),
        .umbral_inferior    (uinf),
        .pop                (pop),
        .push_out           (push_out),
        .data_out           (data_out),
        .idle               (idle)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic upd_empty();
        for (int k = 0; k < 4; k++) fifo_empty[k] = (hd[k] == tl[k]);
    endtask

    task automatic enq(input int k, input logic [9:0] w);
        mem[k][tl[k]] = w;
        tl[k]++;
        upd_empty();
    endtask

    // One clock: a popped source FIFO presents the popped word on its data_out.
    task automatic tick();
        logic [3:0] p;
        p = pop;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (p[k] && hd[k] != tl[k]) begin
                din[k] = mem[k][hd[k]];
                hd[k]++;
            end
        end
        upd_empty();
        #1;
    endtask

    task automatic drain_to_idle(input string name);
        for (int c = 0; c < 200 && !idle; c++) tick();
        n_cmp++;
        if (idle !== 1'b1) begin
            n_err++;
            $display("FAIL %s drain: idle=%b want 1 (state=%b)", name, idle, state);
        end
    endtask

    task automatic test_reset_init();
        reset = 1'b1; init = 1'b0; usup_in = 3'd0; uinf_in = 3'd0; af = 1'b0;
        tick(); tick();
        n_cmp++;
        if (state !== 4'b0001 || pop !== 4'b0 || push_out !== 1'b0 || data_out !== 10'd0
            || idle !== 1'b0) begin
            n_err++;
            $display("FAIL reset outputs: state=%b pop=%b push=%b data=%h idle=%b want 0001/0/0/0/0",
                     state, pop, push_out, data_out, idle);
        end
        n_cmp++;
        if (usup !== 3'd6 || uinf !== 3'd1) begin
            n_err++;
            $display("FAIL reset thresholds: got %0d/%0d want 6/1", usup, uinf);
        end
        reset = 1'b0; init = 1'b1; usup_in = 3'd5; uinf_in = 3'd2;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (state !== 4'b0010 || pop !== 4'b0) begin
                n_err++;
                $display("FAIL init hold c%0d: state=%b pop=%b want 0010/0000", c, state, pop);
            end
        end
        init = 1'b0;
        tick();
        n_cmp++;
        if (state !== 4'b0100 || idle !== 1'b1 || usup !== 3'd5 || uinf !== 3'd2) begin
            n_err++;
            $display("FAIL init exit: state=%b idle=%b thr=%0d/%0d want 0100/1/5/2",
                     state, idle, usup, uinf);
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] exp_w;
        logic       exp_p;
        exp_p = 1'b0; exp_w = '0;
        for (int k = 0; k < 4; k++) begin
            enq(k, 10'($urandom));
            enq(k, 10'($urandom));
        end
        #1;
        tick();
        for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (pop !== 4'(1 << (j % 4)) || $countones(pop) != 1) begin
                n_err++;
                $display("FAIL rr_order step%0d: pop=%b want %b", j, pop, 4'(1 << (j % 4)));
            end
            if (j > 0) begin
                n_cmp++;
                if (push_out !== exp_p || data_out !== exp_w) begin
                    n_err++;
                    $display("FAIL rr_push step%0d: push=%b data=%h want 1/%h",
                             j, push_out, data_out, exp_w);
                end
            end
            exp_w = mem[j % 4][hd[j % 4]];
            exp_p = 1'b1;
            tick();
        end
        drain_to_idle("rr");
    endtask

    task automatic test_single_vc();
        enq(2, 10'h155);
        enq(2, 10'h2AA);
        #1;
        tick();
        n_cmp++;
        if (state !== 4'b1000 || pop !== 4'b0100 || push_out !== 1'b0) begin
            n_err++;
            $display("FAIL single c1: state=%b pop=%b push=%b want 1000/0100/0", state, pop, push_out);
        end
        tick();
        n_cmp++;
        if (pop !== 4'b0100 || push_out !== 1'b1 || data_out !== 10'h155) begin
            n_err++;
            $display("FAIL single c2: pop=%b push=%b data=%h want 0100/1/155", pop, push_out, data_out);
        end
        tick();
        n_cmp++;
        if (pop !== 4'b0000 || push_out !== 1'b1 || data_out !== 10'h2AA) begin
            n_err++;
            $display("FAIL single c3: pop=%b push=%b data=%h want 0000/1/2aa", pop, push_out, data_out);
        end
        tick();
        n_cmp++;
        if (push_out !== 1'b0 || data_out !== 10'h000) begin
            n_err++;
            $display("FAIL single c4: push=%b data=%h want 0/000", push_out, data_out);
        end
        tick();
        n_cmp++;
        if (state !== 4'b0100 || idle !== 1'b1) begin
            n_err++;
            $display("FAIL single idle: state=%b idle=%b want 0100/1", state, idle);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] w1, w2;
        w1 = 10'($urandom); w2 = 10'($urandom);
        enq(1, w1);
        enq(2, w2);
        #1;
        tick();
        n_cmp++;
        if (pop !== 4'b0010) begin
            n_err++;
            $display("FAIL bp first_pop: pop=%b want 0010", pop);
        end
        tick();
        af = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (pop !== 4'b0000 || push_out !== (c == 0) || data_out !== ((c == 0) ? w1 : 10'd0)) begin
                n_err++;
                $display("FAIL bp hold c%0d: pop=%b push=%b data=%h want 0000/%0d/%h",
                         c, pop, push_out, data_out, c == 0, (c == 0) ? w1 : 10'd0);
            end
            if (c < 2) tick();
        end
        tick();
        af = 1'b0;
        #1;
        n_cmp++;
        if (pop !== 4'b0100) begin
            n_err++;
            $display("FAIL bp resume: pop=%b want 0100", pop);
        end
        tick();
        n_cmp++;
        if (push_out !== 1'b1 || data_out !== w2) begin
            n_err++;
            $display("FAIL bp resume_push: push=%b data=%h want 1/%h", push_out, data_out, w2);
        end
        drain_to_idle("bp");
    endtask

    task automatic test_reinit();
        logic [9:0] w0;
        w0 = 10'($urandom);
        enq(0, w0);
        enq(0, 10'($urandom));
        enq(0, 10'($urandom));
        #1;
        tick();
        n_cmp++;
        if (pop !== 4'b0001) begin
            n_err++;
            $display("FAIL reinit pop: pop=%b want 0001", pop);
        end
        tick();
        init = 1'b1; usup_in = 3'd7; uinf_in = 3'd0;
        #1;
        n_cmp++;
        if (pop !== 4'b0000 || push_out !== 1'b1 || data_out !== w0) begin
            n_err++;
            $display("FAIL reinit pending: pop=%b push=%b data=%h want 0000/1/%h",
                     pop, push_out, data_out, w0);
        end
        tick();
        n_cmp++;
        if (state !== 4'b0010 || pop !== 4'b0000 || push_out !== 1'b0) begin
            n_err++;
            $display("FAIL reinit state: state=%b pop=%b push=%b want 0010/0000/0",
                     state, pop, push_out);
        end
        tick();
        n_cmp++;
        if (usup !== 3'd7 || uinf !== 3'd0) begin
            n_err++;
            $display("FAIL reinit thresholds: got %0d/%0d want 7/0", usup, uinf);
        end
        init = 1'b0;
        tick();
        n_cmp++;
        if (idle !== 1'b1 || state !== 4'b0100) begin
            n_err++;
            $display("FAIL reinit idle: idle=%b state=%b want 1/0100", idle, state);
        end
        usup_in = 3'd3; uinf_in = 3'd3;
        drain_to_idle("reinit");
        n_cmp++;
        if (usup !== 3'd7 || uinf !== 3'd0) begin
            n_err++;
            $display("FAIL reinit stable: got %0d/%0d want 7/0", usup, uinf);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) enq(1, 10'($urandom));
        #1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        tick();
        n_cmp++;
        if (push_out !== 1'b0 || data_out !== 10'd0 || state !== 4'b0001 || pop !== 4'b0) begin
            n_err++;
            $display("FAIL midrst outputs: push=%b data=%h state=%b pop=%b want 0/000/0001/0000",
                     push_out, data_out, state, pop);
        end
        n_cmp++;
        if (usup !== 3'd6 || uinf !== 3'd1) begin
            n_err++;
            $display("FAIL midrst thresholds: got %0d/%0d want 6/1", usup, uinf);
        end
        for (int k = 0; k < 4; k++) hd[k] = tl[k];
        upd_empty();
        reset = 1'b0; init = 1'b0; usup_in = 3'd6; uinf_in = 3'd1;
        tick();
        tick();
        n_cmp++;
        if (state !== 4'b0100) begin
            n_err++;
            $display("FAIL midrst recover: state=%b want 0100", state);
        end
    endtask

    // Random traffic after a reset, so the model starts with VC3 as the last grant.
    task automatic test_random();
        int         exp_last;
        bit         exp_active, exp_push, cur_push, any;
        logic [9:0] exp_data;
        logic [3:0] exp_pop;
        int         g;
        exp_last = 3; exp_active = 1'b0; exp_push = 1'b0; exp_data = '0;
        for (int i = 0; i < 400; i++) begin
            af = ($urandom_range(0, 3) == 0);
            usup_in = 3'($urandom); uinf_in = 3'($urandom);
            if (i < 340)
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 2) == 0) enq(k, 10'($urandom));
            #1;
            exp_pop = '0; g = -1;
            if (exp_active && !af)
                for (int s = 1; s <= 4 && g < 0; s++)
                    if (hd[(exp_last + s) % 4] != tl[(exp_last + s) % 4]) g = (exp_last + s) % 4;
            if (g >= 0) exp_pop[g] = 1'b1;
            n_cmp++;
            if (pop !== exp_pop || push_out !== exp_push || data_out !== (exp_push ? exp_data : 10'd0)
                || state !== (exp_active ? 4'b1000 : 4'b0100)) begin
                n_err++;
                $display("FAIL rand cyc%0d: pop=%b push=%b data=%h state=%b want %b/%b/%h/%b", i,
                         pop, push_out, data_out, state, exp_pop, exp_push,
                         exp_push ? exp_data : 10'd0, exp_active ? 4'b1000 : 4'b0100);
            end
            cur_push = exp_push;
            exp_push = (g >= 0);
            if (g >= 0) begin
                exp_data = mem[g][hd[g]];
                exp_last = g;
            end
            any = 1'b0;
            for (int k = 0; k < 4; k++) if (hd[k] != tl[k]) any = 1'b1;
            if (!exp_active) exp_active = any;
            else if (!any && !cur_push) exp_active = 1'b0;
            tick();
        end
        af = 1'b0;
        drain_to_idle("rand");
        n_cmp++;
        if (usup !== 3'd6 || uinf !== 3'd1) begin
            n_err++;
            $display("FAIL rand thresholds: got %0d/%0d want 6/1", usup, uinf);
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            hd[k] = 0; tl[k] = 0; din[k] = '0;
        end
        upd_empty();
        test_reset_init();
        test_round_robin();
        test_single_vc();
        test_backpressure();
        test_reinit();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
